mem_access_unit: RTL and testbench

- MEM-stage block directly downstream of the EX stage.
- Consumes EX outputs: address = ALUResult, store data, MemReadType, MemRead/MemWrite, write-back controls, PC, exception code.
- Drives an SRAM-like data-cache port (req/addr_ok/data_ok) through a small FSM and holds the pipeline via stall until the access completes.
- Generates store byte strobes, aligns and extends load data, and raises address-error exceptions before any request is issued.

---
 rtl/mem_access_unit.sv | 174 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: drives the SRAM-like data-cache port, stalls the pipeline until the
// access completes, builds store strobes/lanes, aligns load data and flags address errors.
module mem_access_unit #(
  parameter logic [3:0] EXC_ADEL = 4'd4,
  parameter logic [3:0] EXC_ADES = 4'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  MemReadType_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] MemData_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic [6:0]  WriteRegister_i,
  input  logic [31:0] PC_i,
  input  logic        is_ds_i,
  input  logic [3:0]  exception_i,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        stall,
  output logic [31:0] ReadData,
  output logic [31:0] ALUResult_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [6:0]  WriteRegister_o,
  output logic [31:0] PC_o,
  output logic        is_ds_o,
  output logic [3:0]  exception_o,
  output logic [31:0] BadVAddr
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrain} stateE;

  stateE       stateQ, stateD;
  logic [31:0] rdataQ;
  logic        capture;
  logic [1:0]  size;
  logic        misaligned;
  logic        memOp;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  logic [31:0] loadVal;
  logic        signFill;

  assign size       = MemReadType_i[1:0];
  assign misaligned = (size == 2'b01 && ALUResult_i[0]) ||
                      (size == 2'b10 && ALUResult_i[1:0] != 2'b00);
  assign memOp      = (MemRead_i | MemWrite_i) && exception_i == 4'd0 && !flush && !misaligned;

  always_comb begin
    exception_o = 4'd0;
    if (exception_i != 4'd0)           exception_o = exception_i;
    else if (MemRead_i && misaligned)  exception_o = EXC_ADEL;
    else if (MemWrite_i && misaligned) exception_o = EXC_ADES;
  end

  assign BadVAddr        = (exception_o == EXC_ADEL || exception_o == EXC_ADES) ? ALUResult_i : '0;
  assign RegWrite_o      = RegWrite_i && exception_o == 4'd0;
  assign ALUResult_o     = ALUResult_i;
  assign MemtoReg_o      = MemtoReg_i;
  assign WriteRegister_o = WriteRegister_i;
  assign PC_o            = PC_i;
  assign is_ds_o         = is_ds_i;

  assign data_wr   = MemWrite_i;
  assign data_size = size;
  assign data_addr = ALUResult_i;

  always_comb begin
    data_wdata = MemData_i;
    data_wstrb = 4'b0000;
    unique case (size)
      2'b00:   data_wdata = {4{MemData_i[7:0]}};
      2'b01:   data_wdata = {2{MemData_i[15:0]}};
      default: data_wdata = MemData_i;
    endcase
    if (MemWrite_i) begin
      unique case (size)
        2'b00:   data_wstrb = 4'b0001 << ALUResult_i[1:0];
        2'b01:   data_wstrb = ALUResult_i[1] ? 4'b1100 : 4'b0011;
        default: data_wstrb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    stateD   = stateQ;
    data_req = 1'b0;
    stall    = 1'b0;
    capture  = 1'b0;
    unique case (stateQ)
      StIdle: begin
        data_req = memOp;
        stall    = memOp;
        if (memOp) stateD = data_addr_ok ? StWait : StReq;
      end
      StReq: begin
        stall = 1'b1;
        // An unaccepted request is simply abandoned on flush.
        if (flush) begin
          stateD = StIdle;
        end else begin
          data_req = 1'b1;
          if (data_addr_ok) stateD = StWait;
        end
      end
      StWait: begin
        stall = 1'b1;
        if (data_data_ok) begin
          capture = !flush;
          stateD  = flush ? StIdle : StDone;
        end else if (flush) begin
          stateD = StDrain;
        end
      end
      StDone: stateD = StIdle;
      StDrain: begin
        stall = 1'b1;
        if (data_data_ok) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
    if (rst) begin
      data_req = 1'b0;
      stall    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StIdle;
      rdataQ <= '0;
    end else begin
      stateQ <= stateD;
      if (capture) rdataQ <= data_rdata;
    end
  end

  // Load lane select relies on ALUResult_i being held stable through DONE.
  always_comb begin
    unique case (ALUResult_i[1:0])
      2'b00:   ldByte = rdataQ[7:0];
      2'b01:   ldByte = rdataQ[15:8];
      2'b10:   ldByte = rdataQ[23:16];
      default: ldByte = rdataQ[31:24];
    endcase
    ldHalf = ALUResult_i[1] ? rdataQ[31:16] : rdataQ[15:0];
    signFill = 1'b0;
    unique case (size)
      2'b00: begin
        signFill = !MemReadType_i[2] && ldByte[7];
        loadVal  = {{24{signFill}}, ldByte};
      end
      2'b01: begin
        signFill = !MemReadType_i[2] && ldHalf[15];
        loadVal  = {{16{signFill}}, ldHalf};
      end
      default: loadVal = rdataQ;
    endcase
  end

  assign ReadData = (stateQ == StDone && MemRead_i && !rst) ? loadVal : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected requests and completions,
// a negedge monitor checks cache requests and instruction retirement independently.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        MemRead_i, MemWrite_i;
  logic [2:0]  MemReadType_i;
  logic [31:0] ALUResult_i, MemData_i;
  logic        RegWrite_i, MemtoReg_i;
  logic [6:0]  WriteRegister_i;
  logic [31:0] PC_i;
  logic        is_ds_i;
  logic [3:0]  exception_i;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        stall;
  logic [31:0] ReadData, ALUResult_o;
  logic        RegWrite_o, MemtoReg_o;
  logic [6:0]  WriteRegister_o;
  logic [31:0] PC_o;
  logic        is_ds_o;
  logic [3:0]  exception_o;
  logic [31:0] BadVAddr;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .MemReadType_i(MemReadType_i),
    .ALUResult_i(ALUResult_i), .MemData_i(MemData_i), .RegWrite_i(RegWrite_i),
    .MemtoReg_i(MemtoReg_i), .WriteRegister_i(WriteRegister_i), .PC_i(PC_i),
    .is_ds_i(is_ds_i), .exception_i(exception_i),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .stall(stall),
    .ReadData(ReadData), .ALUResult_o(ALUResult_o), .RegWrite_o(RegWrite_o),
    .MemtoReg_o(MemtoReg_o), .WriteRegister_o(WriteRegister_o), .PC_o(PC_o),
    .is_ds_o(is_ds_o), .exception_o(exception_o), .BadVAddr(BadVAddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reqT;

  typedef struct {
    logic [31:0] readData;
    logic [3:0]  exc;
    logic [31:0] badv;
    logic        regWrite;
    logic [31:0] pc;
    int          stallCycles;
  } cmpT;

  reqT         reqQ[$];
  cmpT         cmpQ[$];
  int          nAsserts = 0;
  int          nFail = 0;
  int          stallCnt = 0;
  logic        present = 1'b0;
  logic [31:0] pc = 32'hBFC00000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAsserts++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: cache-side request checks and retirement checks.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_req) begin
        if (reqQ.size() == 0) begin
          check("unexpectedReq", {31'd0, data_req}, 32'd0);
        end else begin
          check("reqAddr", data_addr, reqQ[0].addr);
          check("reqWr", {31'd0, data_wr}, {31'd0, reqQ[0].wr});
          check("reqSize", {30'd0, data_size}, {30'd0, reqQ[0].size});
          check("reqWdata", data_wdata, reqQ[0].wdata);
          check("reqWstrb", {28'd0, data_wstrb}, {28'd0, reqQ[0].wstrb});
          if (data_addr_ok) void'(reqQ.pop_front());
        end
      end
      if (present) begin
        if (stall) begin
          stallCnt++;
          check("readDataWhileStalled", ReadData, 32'd0);
        end else if (cmpQ.size() == 0) begin
          check("unexpectedRetire", 32'd1, 32'd0);
        end else begin
          check("readData", ReadData, cmpQ[0].readData);
          check("exception", {28'd0, exception_o}, {28'd0, cmpQ[0].exc});
          check("badVAddr", BadVAddr, cmpQ[0].badv);
          check("regWrite", {31'd0, RegWrite_o}, {31'd0, cmpQ[0].regWrite});
          check("pcPass", PC_o, cmpQ[0].pc);
          check("stallCycles", stallCnt, cmpQ[0].stallCycles);
          void'(cmpQ.pop_front());
          stallCnt = 0;
        end
      end else begin
        stallCnt = 0;
      end
    end
  end

  task automatic clearOp();
    MemRead_i = 1'b0; MemWrite_i = 1'b0; MemReadType_i = 3'b010;
    ALUResult_i = '0; MemData_i = '0; RegWrite_i = 1'b0; MemtoReg_i = 1'b0;
    WriteRegister_i = '0; is_ds_i = 1'b0; exception_i = '0;
  endtask

  task automatic setOp(input logic rd, input logic wr, input logic [2:0] typ,
                       input logic [31:0] addr, input logic [31:0] mdata, input logic regw,
                       input logic [3:0] excIn);
    MemRead_i = rd; MemWrite_i = wr; MemReadType_i = typ; ALUResult_i = addr;
    MemData_i = mdata; RegWrite_i = regw; MemtoReg_i = rd; WriteRegister_i = 7'd5;
    exception_i = excIn;
    pc = pc + 32'd4;
    PC_i = pc;
  endtask

  // Runs one instruction with a cache model; entered and left at posedge+1.
  task automatic runOp(input logic rd, input logic wr, input logic [2:0] typ,
                       input logic [31:0] addr, input logic [31:0] mdata,
                       input logic [31:0] rdata, input logic regw, input logic [3:0] excIn,
                       input int aokDelay, input int dokDelay, input logic [31:0] expRead,
                       input logic [3:0] expExc, input logic [31:0] expWdata,
                       input logic [3:0] expWstrb, input int expStall);
    int   phase = 0;
    int   cnt = 0;
    logic doneNow = 1'b0;
    setOp(rd, wr, typ, addr, mdata, regw, excIn);
    if (expExc == 4'd0) reqQ.push_back('{addr, wr, typ[1:0], expWdata, expWstrb});
    cmpQ.push_back('{expRead, expExc, (expExc == 4'd4 || expExc == 4'd5) ? addr : 32'd0,
                     regw && expExc == 4'd0, pc, expStall});
    present = 1'b1;
    for (int cyc = 0; cyc < 50 && !doneNow; cyc++) begin
      #1;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'hCAFEBABE;
      if (phase == 0) begin
        if (data_req) begin
          if (cnt == aokDelay) begin
            data_addr_ok = 1'b1; phase = 1; cnt = 0;
          end else cnt++;
        end
      end else if (phase == 1) begin
        if (cnt == dokDelay) begin
          data_data_ok = 1'b1; data_rdata = rdata; phase = 2;
        end else cnt++;
      end
      #1;
      doneNow = !stall;
      @(posedge clk); #1;
    end
    check("opCompletes", {31'd0, doneNow}, 32'd1);
    present = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    clearOp();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; PC_i = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    clearOp();
    setOp(1'b1, 1'b0, 3'b010, 32'h80000000, 32'd0, 1'b1, 4'd0);
    data_addr_ok = 1'b1;
    @(negedge clk);
    check("resetReq", {31'd0, data_req}, 32'd0);
    check("resetStall", {31'd0, stall}, 32'd0);
    check("resetReadData", ReadData, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; data_addr_ok = 1'b0;
    clearOp();
    @(posedge clk); #1;

    // Loads: best case, lane/extension variants, slower data_ok.
    runOp(1, 0, 3'b010, 32'h80001004, 0, 32'hDEADBEEF, 1, 0, 0, 0, 32'hDEADBEEF, 0, 0, 4'b0000, 2);
    runOp(1, 0, 3'b000, 32'h80001003, 0, 32'h80FF1234, 1, 0, 0, 0, 32'hFFFFFF80, 0, 0, 4'b0000, 2);
    runOp(1, 0, 3'b100, 32'h80001003, 0, 32'h80FF1234, 1, 0, 0, 0, 32'h00000080, 0, 0, 4'b0000, 2);
    runOp(1, 0, 3'b001, 32'h80001002, 0, 32'h80FF1234, 1, 0, 0, 0, 32'hFFFF80FF, 0, 0, 4'b0000, 2);
    runOp(1, 0, 3'b000, 32'h80001001, 0, 32'h80FF1234, 1, 0, 0, 2, 32'h00000012, 0, 0, 4'b0000, 4);
    runOp(1, 0, 3'b101, 32'h80001000, 0, 32'h80FF9234, 1, 0, 0, 0, 32'h00009234, 0, 0, 4'b0000, 2);

    // Stores.
    runOp(0, 1, 3'b000, 32'h80001001, 32'h000000AB, 0, 0, 0, 0, 0, 0, 0, 32'hABABABAB, 4'b0010, 2);
    runOp(0, 1, 3'b001, 32'h80001002, 32'h0000BEEF, 0, 0, 0, 0, 0, 0, 0, 32'hBEEFBEEF, 4'b1100, 2);
    runOp(0, 1, 3'b010, 32'h80001008, 32'h11223344, 0, 0, 0, 1, 0, 0, 0, 32'h11223344, 4'b1111, 3);

    // Address errors and an upstream exception: no request, no stall.
    runOp(1, 0, 3'b010, 32'h80001002, 0, 0, 1, 0, 0, 0, 0, 4'd4, 0, 0, 0);
    runOp(0, 1, 3'b001, 32'h80001001, 32'h1234, 0, 0, 0, 0, 0, 0, 4'd5, 0, 0, 0);
    runOp(1, 0, 3'b010, 32'h80001000, 0, 0, 1, 4'd8, 0, 0, 0, 4'd8, 0, 0, 0);

    // addr_ok withheld for three cycles.
    runOp(1, 0, 3'b010, 32'h80002000, 0, 32'h0BADF00D, 1, 0, 3, 0, 32'h0BADF00D, 0, 0, 4'b0000, 5);

    // Flush while the request is still unaccepted.
    setOp(1'b1, 1'b0, 3'b010, 32'h80003000, 32'd0, 1'b1, 4'd0);
    reqQ.push_back('{32'h80003000, 1'b0, 2'b10, 32'd0, 4'b0000});
    @(posedge clk); #1;
    @(negedge clk);
    check("reqHeldInReq", {31'd0, data_req}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flushReqDrop", {31'd0, data_req}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    clearOp();
    reqQ.delete();
    @(negedge clk);
    check("flushReqIdle", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;

    // Flush while waiting for data: drain until data_ok arrives.
    setOp(1'b1, 1'b0, 3'b010, 32'h80004000, 32'd0, 1'b1, 4'd0);
    reqQ.push_back('{32'h80004000, 1'b0, 2'b10, 32'd0, 4'b0000});
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("drainStall", {31'd0, stall}, 32'd1);
    check("drainReadData", ReadData, 32'd0);
    check("drainNoReq", {31'd0, data_req}, 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b1; data_rdata = 32'h12345678;
    @(negedge clk);
    check("drainStallAtOk", {31'd0, stall}, 32'd1);
    check("drainReadDataAtOk", ReadData, 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    clearOp();
    @(negedge clk);
    check("drainToIdle", {31'd0, stall}, 32'd0);
    check("drainDiscard", ReadData, 32'd0);
    @(posedge clk); #1;

    // Normal traffic after the drain.
    runOp(1, 0, 3'b010, 32'h80005000, 0, 32'hA5A5A5A5, 1, 0, 0, 0, 32'hA5A5A5A5, 0, 0, 4'b0000, 2);

    repeat (2) @(posedge clk);
    check("reqQueueEmpty", reqQ.size(), 32'd0);
    check("cmpQueueEmpty", cmpQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
